// File: rtl/true_dual_port_bram_core.sv
// True dual-port RAM on one clock: two independent read/write ports, sync or async reads,
// write-first/read-first semantics, single-port mode and a registered same-address collision flag.
module true_dual_port_bram_core #(
  parameter int DWIDTH      = 8,
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int READ_SYNC   = 1,
  parameter int WRITE_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              singleportmode,
  input  logic              port_en_0,
  input  logic              wr_en_0,
  input  logic [ADDR_W-1:0] addr_in_0,
  input  logic [DWIDTH-1:0] data_in_0,
  output logic [DWIDTH-1:0] data_out_0,
  input  logic              port_en_1,
  input  logic              wr_en_1,
  input  logic [ADDR_W-1:0] addr_in_1,
  input  logic [DWIDTH-1:0] data_in_1,
  output logic [DWIDTH-1:0] data_out_1,
  output logic              collision_flag
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam bit              WF      = (WRITE_FIRST != 0);

  logic [DWIDTH-1:0] mem [DEPTH];

  logic              en1_eff, act_0, act_1;
  logic              in_rng_0, in_rng_1, we_0, we_1;
  logic              same_addr, coll_now;
  logic [DWIDTH-1:0] mem_rd_0, mem_rd_1;
  logic [DWIDTH-1:0] dout_0_d, dout_0_q, dout_1_d, dout_1_q;
  logic              coll_d, coll_q;

  always_comb begin
    en1_eff   = port_en_1 & ~singleportmode;
    act_0     = clk_en & port_en_0;
    act_1     = clk_en & en1_eff;
    in_rng_0  = {1'b0, addr_in_0} < DEPTH_L;
    in_rng_1  = {1'b0, addr_in_1} < DEPTH_L;
    we_0      = act_0 & wr_en_0 & in_rng_0;
    we_1      = act_1 & wr_en_1 & in_rng_1;
    same_addr = (addr_in_0 == addr_in_1);
    mem_rd_0  = in_rng_0 ? mem[addr_in_0] : '0;
    mem_rd_1  = in_rng_1 ? mem[addr_in_1] : '0;
  end

  always_comb begin
    dout_0_d = dout_0_q;
    dout_1_d = dout_1_q;
    // A reader sharing an address with the other port's write sees the new word only in write-first mode
    if (act_0) begin
      if (wr_en_0)                    dout_0_d = WF ? data_in_0 : mem_rd_0;
      else if (WF && we_1 && same_addr) dout_0_d = data_in_1;
      else                            dout_0_d = mem_rd_0;
    end
    if (act_1) begin
      if (wr_en_1)                    dout_1_d = WF ? data_in_1 : mem_rd_1;
      else if (WF && we_0 && same_addr) dout_1_d = data_in_0;
      else                            dout_1_d = mem_rd_1;
    end
    coll_now = act_0 & act_1 & same_addr & (wr_en_0 | wr_en_1);
    coll_d   = clk_en ? coll_now : coll_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_0_q <= '0;
      dout_1_q <= '0;
      coll_q   <= 1'b0;
    end else begin
      dout_0_q <= dout_0_d;
      dout_1_q <= dout_1_d;
      coll_q   <= coll_d;
    end
  end

  // Port 0 is written last so it wins a same-address write-write
  always_ff @(posedge clk) begin
    if (we_1) mem[addr_in_1] <= data_in_1;
    if (we_0) mem[addr_in_0] <= data_in_0;
  end

  generate
    if (READ_SYNC != 0) begin : g_sync
      assign data_out_0 = dout_0_q;
      assign data_out_1 = dout_1_q;
    end else begin : g_async
      assign data_out_0 = port_en_0 ? mem_rd_0 : '0;
      assign data_out_1 = en1_eff   ? mem_rd_1 : '0;
    end
  endgenerate

  assign collision_flag = coll_q;

endmodule

// File: tb/tb_true_dual_port_bram_core.sv
// Drives three RAM flavours (sync write-first, sync read-first, async) with shared stimulus
// and compares them against an array-based model of the memory contents and port rules.
module tb_true_dual_port_bram_core;

  localparam int DW = 8;
  localparam int DP = 200;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_en = 1'b0, singleportmode = 1'b0;
  logic          port_en_0 = 1'b0, wr_en_0 = 1'b0, port_en_1 = 1'b0, wr_en_1 = 1'b0;
  logic [AW-1:0] addr_in_0 = '0, addr_in_1 = '0;
  logic [DW-1:0] data_in_0 = '0, data_in_1 = '0;

  logic [DW-1:0] wf_o0, wf_o1, rf_o0, rf_o1, as_o0, as_o1;
  logic          wf_col, rf_col, as_col;

  always #5 clk = ~clk;

  true_dual_port_bram_core #(.DWIDTH(DW), .DEPTH(DP), .ADDR_W(AW), .READ_SYNC(1), .WRITE_FIRST(1)) u_wf (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .singleportmode(singleportmode),
    .port_en_0(port_en_0), .wr_en_0(wr_en_0), .addr_in_0(addr_in_0), .data_in_0(data_in_0), .data_out_0(wf_o0),
    .port_en_1(port_en_1), .wr_en_1(wr_en_1), .addr_in_1(addr_in_1), .data_in_1(data_in_1), .data_out_1(wf_o1),
    .collision_flag(wf_col));

  true_dual_port_bram_core #(.DWIDTH(DW), .DEPTH(DP), .ADDR_W(AW), .READ_SYNC(1), .WRITE_FIRST(0)) u_rf (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .singleportmode(singleportmode),
    .port_en_0(port_en_0), .wr_en_0(wr_en_0), .addr_in_0(addr_in_0), .data_in_0(data_in_0), .data_out_0(rf_o0),
    .port_en_1(port_en_1), .wr_en_1(wr_en_1), .addr_in_1(addr_in_1), .data_in_1(data_in_1), .data_out_1(rf_o1),
    .collision_flag(rf_col));

  true_dual_port_bram_core #(.DWIDTH(DW), .DEPTH(DP), .ADDR_W(AW), .READ_SYNC(0), .WRITE_FIRST(1)) u_as (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .singleportmode(singleportmode),
    .port_en_0(port_en_0), .wr_en_0(wr_en_0), .addr_in_0(addr_in_0), .data_in_0(data_in_0), .data_out_0(as_o0),
    .port_en_1(port_en_1), .wr_en_1(wr_en_1), .addr_in_1(addr_in_1), .data_in_1(data_in_1), .data_out_1(as_o1),
    .collision_flag(as_col));

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  logic [DW-1:0] mm [256];
  logic [DW-1:0] e_wf0 = '0, e_wf1 = '0, e_rf0 = '0, e_rf1 = '0;
  logic          e_col = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd_mem(input logic [AW-1:0] a);
    return (int'(a) < DP) ? mm[a] : '0;
  endfunction

  task automatic step(input bit ce, input bit spm,
                      input bit e0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input bit e1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    logic [DW-1:0] nm [256];
    logic [DW-1:0] old0, old1;
    bit act0, act1;
    @(negedge clk);
    if (chk_on) begin
      chk("wf_o0", wf_o0, e_wf0);  chk("wf_o1", wf_o1, e_wf1);
      chk("rf_o0", rf_o0, e_rf0);  chk("rf_o1", rf_o1, e_rf1);
      chk("wf_col", wf_col, e_col); chk("rf_col", rf_col, e_col); chk("as_col", as_col, e_col);
    end
    clk_en = ce; singleportmode = spm;
    port_en_0 = e0; wr_en_0 = w0; addr_in_0 = a0; data_in_0 = d0;
    port_en_1 = e1; wr_en_1 = w1; addr_in_1 = a1; data_in_1 = d1;
    #1;
    old0 = rd_mem(a0);
    old1 = rd_mem(a1);
    if (chk_on) begin
      chk("as_o0", as_o0, e0 ? old0 : 8'h00);
      chk("as_o1", as_o1, (e1 && !spm) ? old1 : 8'h00);
    end
    act0 = ce && e0;
    act1 = ce && e1 && !spm;
    nm = mm;
    if (act1 && w1 && int'(a1) < DP) nm[a1] = d1;
    if (act0 && w0 && int'(a0) < DP) nm[a0] = d0;
    if (act0) begin
      e_wf0 = w0 ? d0 : ((int'(a0) < DP) ? nm[a0] : 8'h00);
      e_rf0 = old0;
    end
    if (act1) begin
      e_wf1 = w1 ? d1 : ((int'(a1) < DP) ? nm[a1] : 8'h00);
      e_rf1 = old1;
    end
    if (ce) e_col = act0 && act1 && (a0 == a1) && (w0 || w1);
    mm = nm;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  function automatic logic [AW-1:0] pick_addr();
    logic [AW-1:0] hot [6];
    hot = '{8'h10, 8'h11, 8'h20, 8'hC7, 8'hC8, 8'hFF};
    if ($urandom_range(0, 99) < 70) return hot[$urandom_range(0, 5)];
    return AW'($urandom_range(0, 255));
  endfunction

  initial begin
    #2;
    chk("rst_wf_o0", wf_o0, 8'h00); chk("rst_wf_o1", wf_o1, 8'h00);
    chk("rst_rf_o0", rf_o0, 8'h00); chk("rst_col", wf_col, 1'b0);
    chk("rst_as_o0", as_o0, 8'h00);
    #10 rst_n = 1'b1;

    for (int i = 0; i < DP; i++)
      step(1'b1, 1'b0, 1'b1, 1'b1, AW'(i), DW'(i * 7 + 3), 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 8'h00);
    chk_on = 1'b1;

    // write then dual read
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'h10, 8'hD0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    idle();
    chk("tp_rd0", wf_o0, 8'hD0); chk("tp_rd1", wf_o1, 8'hD0); chk("tp_nocol", wf_col, 1'b0);

    // cross-port write/read
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'h10, 8'hF1, 1'b1, 1'b0, 8'h10, 8'h00);
    idle();
    chk("tp_xcol", wf_col, 1'b1); chk("tp_x_wf", wf_o1, 8'hF1); chk("tp_x_rf", rf_o1, 8'hD0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    idle();
    chk("tp_x_rd", rf_o1, 8'hF1); chk("tp_x_col0", rf_col, 1'b0);

    // write-write collision
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'h20, 8'hA5, 1'b1, 1'b1, 8'h20, 8'h5A);
    idle();
    chk("tp_ww_col", wf_col, 1'b1); chk("tp_ww_o1", wf_o1, 8'h5A);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    idle();
    chk("tp_ww_rd", wf_o0, 8'hA5);

    // clock enable low
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'h30, 8'h33, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h30, 8'h77, 1'b0, 1'b0, 8'h00, 8'h00);
    idle();
    chk("tp_ce_hold", wf_o0, 8'h33);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    idle();
    chk("tp_ce_mem", rf_o0, 8'h33);

    // single-port mode
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h40, 8'h22, 1'b1, 1'b1, 8'h40, 8'h11);
    idle();
    chk("tp_spm_col", wf_col, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    idle();
    chk("tp_spm_rd", wf_o0, 8'h22);

    // asynchronous reset in the middle of a read
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'h50, 8'h9C, 1'b1, 1'b1, 8'h50, 8'h3E);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_wf_o0", wf_o0, 8'h00); chk("mr_wf_o1", wf_o1, 8'h00);
    chk("mr_rf_o0", rf_o0, 8'h00); chk("mr_rf_o1", rf_o1, 8'h00);
    chk("mr_col", wf_col, 1'b0);   chk("mr_as_o0", as_o0, mm[8'h10]);
    e_wf0 = '0; e_wf1 = '0; e_rf0 = '0; e_rf1 = '0; e_col = 1'b0;
    #1 rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h50, 8'h00);
    idle();
    chk("mr_keep", wf_o0, 8'hF1);

    // out-of-range boundary
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'hC8, 8'hEE, 1'b1, 1'b0, 8'hC7, 8'h00);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'hC8, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    idle();
    chk("oor_rd", wf_o0, 8'h00);

    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 80, $urandom_range(0, 1) == 1, pick_addr(), DW'($urandom),
           $urandom_range(0, 99) < 80, $urandom_range(0, 1) == 1, pick_addr(), DW'($urandom));
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/true_dual_port_bram_core.md
# true_dual_port_bram_core

Parameterised true dual-port block RAM with two independent read/write ports sharing one clock. It serves as the shared on-chip storage primitive between two requesters. It supports synchronous (registered) or asynchronous (combinational) reads, plus write-first or read-first same-port semantics. A single-port mode disables port 1, and a registered collision flag reports same-address conflicts between the ports.

## Interface
- DWIDTH, 8: data width in bits.
- DEPTH, 256: number of words.
- ADDR_W, 8: address width; DEPTH ≤ 2^ADDR_W.
- READ_SYNC, 1: 1 = registered read outputs; 0 = combinational read outputs.
- WRITE_FIRST, 1: 1 = write-first; 0 = read-first.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clk_en  in  1  global clock enable; 0 freezes all synchronous state except reset.
- singleportmode  in  1  1 = port 1 disabled.
- port_en_0  in  1  port 0 enable.
- wr_en_0  in  1  port 0 write (1) / read (0).
- addr_in_0  in  ADDR_W  port 0 address.
- data_in_0  in  DWIDTH  port 0 write data.
- data_out_0  out  DWIDTH  port 0 read data.
- port_en_1, wr_en_1, addr_in_1, data_in_1, data_out_1: same as port 0, for port 1.
- collision_flag  out  1  registered same-address conflict indicator.

## Operation
- Effective port-1 enable is port_en_1 AND NOT singleportmode.
- A port is "active" on an edge when clk_en=1 and its effective enable is 1.
- Write: on the rising edge, an active port with wr_en=1 writes mem[addr] <= data_in.
- Write-write, same address, both active: port 0's data is stored.
- Out-of-range address (addr ≥ DEPTH):
  - write ignored;
  - read returns 0.
- Memory array is not cleared by reset; contents are undefined until written.
- Sync read (READ_SYNC=1), for an active port:
  - read: data_out <= mem[addr];
  - write with WRITE_FIRST=1: data_out <= data_in;
  - write with WRITE_FIRST=0: data_out <= old mem[addr].
  - An inactive port holds data_out.
- Cross-port read/write, sync mode, same address (one port reads, the other writes on the same edge):
  - WRITE_FIRST=1: reader captures the written data;
  - WRITE_FIRST=0: reader captures the old contents.
  - For a write-write collision, both outputs follow their own port's same-port rule.
- Async read (READ_SYNC=0): data_out = mem[addr] when the effective port enable = 1, else 0. This path is independent of clk_en and wr_en; a written value appears after the write edge.
- singleportmode=1:
  - port 1 never writes;
  - data_out_1 is 0 in async mode and holds its value in sync mode;
  - no collisions are reported.
- Collision:
  - Condition on an edge: clk_en=1, both ports active, addr_in_0 == addr_in_1, and at least one wr_en=1.
  - collision_flag <= condition on each edge with clk_en=1, so it is held when clk_en=0.
  - The flag is registered in both READ_SYNC modes.

## Timing
- Reset (rst_n=0, asynchronous): data_out_0 and data_out_1 registers = 0, collision_flag = 0. Async-mode outputs still follow the memory array.
- Write latency: 1 edge.
- Sync read latency: data valid after the first rising edge following the request; held until the next active access.
- Async read latency: combinational, 0 cycles.
- collision_flag is high for the cycle after the colliding edge and stays high while collisions continue on consecutive edges.
- Reset deasserted mid-operation: the first edge after release behaves normally; no partial writes occur during reset.

## Test plan
- clk_en=1: port 0 writes 0x10=0xD0; next cycle both ports read 0x10.
  - Sync: data_out_0 = data_out_1 = 0xD0 one edge later, collision_flag = 0.
  - Async: 0xD0 immediately.
- Port 0 writes 0x10=0xF1 while port 1 reads 0x10 on the same edge.
  - collision_flag = 1 next cycle.
  - Sync data_out_1 = 0xF1 (WRITE_FIRST=1) or 0xD0 (WRITE_FIRST=0).
  - Port 1 reads 0x10 again: 0xF1, flag back to 0.
- Both ports write 0x20 (port 0 0xA5, port 1 0x5A) → collision_flag = 1; a subsequent read of 0x20 returns 0xA5.
- clk_en=0 with a port 0 write of 0x30=0x77 → memory unchanged and sync outputs unchanged; async outputs still track the address.
- singleportmode=1: port 1 writes 0x40=0x11 and port 0 writes 0x40=0x22 → no collision flag; mem[0x40] = 0x22; port 1 write discarded.
- Assert rst_n=0 asynchronously mid-read → sync data_out_* and collision_flag = 0 immediately; previously written contents remain readable after release.
